// File: rtl/crc_msg_pkg.sv
// Shared constants and state encoding for the CRC message loader.
package crc_msg_pkg;

  localparam int WORDS     = 8;          // buffer depth in 32-bit words
  localparam int MAX_BYTES = 4 * WORDS;  // longest message the buffer holds
  localparam int LEN_W     = 6;          // result length width (must hold 32)
  localparam int BCNT_W    = 5;          // byte index width inside a message

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_RUN    = 2'd1,
    S_RESULT = 2'd2,
    S_DROP   = 2'd3
  } state_e;

  // Byte count of a message whose final byte sits at index idx.
  function automatic logic [LEN_W-1:0] len_of(input logic [BCNT_W-1:0] idx);
    return {1'b0, idx} + LEN_W'(1);
  endfunction

endpackage

// File: rtl/crc_msg_buf.sv
// 8 x 32 message buffer: byte-lane writes, big-endian lanes, async read.
module crc_msg_buf
  import crc_msg_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  widx,
  input  logic [7:0]  wbyte,
  input  logic [2:0]  raddr,
  output logic [31:0] rdata
);

  // Contents are deliberately not reset; the driver only reads written lanes.
  logic [WORDS-1:0][31:0] mem_q;
  logic [31:0]            wword_d;

  // Merge the incoming byte into its word; lane 0 is the most significant byte.
  always_comb begin
    wword_d = mem_q[widx[4:2]];
    case (widx[1:0])
      2'd0:    wword_d[31:24] = wbyte;
      2'd1:    wword_d[23:16] = wbyte;
      2'd2:    wword_d[15:8]  = wbyte;
      default: wword_d[7:0]   = wbyte;
    endcase
  end

  // Word write-back of the merged lane.
  always_ff @(posedge clk) begin
    if (we) mem_q[widx[4:2]] <= wword_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/crc_msg_loader.sv
// Packs a byte stream into the message buffer, runs the CRC driver and
// returns the captured CRC with the message length on a result handshake.
module crc_msg_loader
  import crc_msg_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        drv_en,
  output logic [7:0]  drv_length,
  input  logic [2:0]  drv_addr,
  output logic [31:0] drv_data,
  input  logic        drv_done,
  input  logic [15:0] drv_crc,
  output logic [15:0] m_crc,
  output logic [5:0]  m_len,
  output logic        m_trunc,
  output logic        m_valid,
  input  logic        m_ready
);

  state_e             state_q;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               drv_en_q;
  logic [7:0]         drv_length_q;
  logic [15:0]        m_crc_q;
  logic [LEN_W-1:0]   m_len_q;
  logic               m_trunc_q;
  logic               m_valid_q;

  logic               fill_we;
  logic               msg_end;

  // Byte input is open only while filling or draining a cut message,
  // and is held closed during reset.
  assign s_ready = nrst & ((state_q == S_FILL) | (state_q == S_DROP));
  assign fill_we = s_valid & s_ready & (state_q == S_FILL);
  // A message ends on its last byte, or when the buffer fills up.
  assign msg_end = s_last | (bcnt_q == BCNT_W'(MAX_BYTES - 1));
  assign bcnt_d  = bcnt_q + BCNT_W'(1);

  crc_msg_buf u_buf (
    .clk   (clk),
    .we    (fill_we),
    .widx  (bcnt_q),
    .wbyte (s_data),
    .raddr (drv_addr),
    .rdata (drv_data)
  );

  // Control FSM with byte counter and registered driver/result outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_FILL;
      bcnt_q       <= '0;
      drv_en_q     <= 1'b0;
      drv_length_q <= '0;
      m_crc_q      <= '0;
      m_len_q      <= '0;
      m_trunc_q    <= 1'b0;
      m_valid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (fill_we) begin
            if (msg_end) begin
              // Counter is left on the final index; cleared after the result.
              state_q      <= S_RUN;
              drv_en_q     <= 1'b1;
              drv_length_q <= {3'b000, bcnt_q};
              m_len_q      <= len_of(bcnt_q);
              m_trunc_q    <= ~s_last;
            end else begin
              bcnt_q <= bcnt_d;
            end
          end
        end
        S_RUN: begin
          if (drv_done) begin
            // Dropping drv_en here lets the driver leave its done state
            // before the next run can start.
            state_q   <= S_RESULT;
            drv_en_q  <= 1'b0;
            m_crc_q   <= drv_crc;
            m_valid_q <= 1'b1;
          end
        end
        S_RESULT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            bcnt_q    <= '0;
            state_q   <= m_trunc_q ? S_DROP : S_FILL;
          end
        end
        default: begin
          // Discard the tail of a cut message up to its last byte.
          if (s_valid && s_last) state_q <= S_FILL;
        end
      endcase
    end
  end

  assign drv_en     = drv_en_q;
  assign drv_length = drv_length_q;
  assign m_crc      = m_crc_q;
  assign m_len      = m_len_q;
  assign m_trunc    = m_trunc_q;
  assign m_valid    = m_valid_q;

endmodule

// File: doc/crc_msg_loader.md
# crc_msg_loader

Upstream feeder for the CRC driver. Accepts a byte stream (valid/ready with last) and packs bytes big-endian into an 8 × 32-bit message buffer. It then launches the driver (`drv_en`), serves its word reads, and captures the 16-bit CRC. The CRC and byte count are presented on a valid/ready result port. Sits between the AXI-facing message source and the CRC driver inside the customCRC IP.

## Interface
- `WORDS`, 8: buffer depth in 32-bit words; matches the driver's 3-bit word address.
- `MAX_BYTES`, 32: max message length, 4 × `WORDS`.
- `clk` in 1: sole clock, rising edge.
- `nrst` in 1: reset, asynchronous and active-low.
- `s_data` in 8: message byte.
- `s_valid` in 1: byte valid.
- `s_last` in 1: final byte of message.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `drv_en` out 1: driver run request.
- `drv_length` out 8: byte count minus 1; the driver processes bytes 0..`drv_length` inclusive.
- `drv_addr` in 3: driver word read address.
- `drv_data` out 32: `buf[drv_addr]`, combinational.
- `drv_done` in 1: driver finished.
- `drv_crc` in 16: driver CRC, valid while `drv_done`.
- `m_crc` out 16: captured CRC.
- `m_len` out 6: message byte count, 1..32.
- `m_trunc` out 1: message was cut at `MAX_BYTES`.
- `m_valid` out 1: result valid.
- `m_ready` in 1: result consumed on `m_valid & m_ready`.

## Operation
- States:
  - `S_FILL`: `s_ready`=1.
  - `S_RUN`: `drv_en`=1.
  - `S_RESULT`: `m_valid`=1.
  - `S_DROP`: `s_ready`=1; bytes are discarded.
- Byte packing: byte `i` (5-bit count `bcnt`) is written to word `i[4:2]`, lane `i[1:0]`.
  - Lane 0 maps to bits [31:24], lane 3 to bits [7:0].
  - Unwritten lanes keep stale contents; the driver never reads them.
- `S_FILL` → `S_RUN`:
  - On an accepted byte with `s_last`=1: `drv_length`←`bcnt`, `m_len`←`bcnt+1`, `m_trunc`←0.
  - On the 32nd accepted byte with `s_last`=0: same captures, but `m_trunc`←1 (message cut at 32 bytes).
- `S_RUN` → `S_RESULT` when `drv_done`=1 is sampled: `m_crc`←`drv_crc`.
- `S_RESULT` on `m_ready`=1:
  - If `m_trunc`=1, go to `S_DROP`; otherwise go to `S_FILL`.
  - In both cases `bcnt`←0.
- `S_DROP`: accepted bytes are ignored. An accepted byte with `s_last` returns the block to `S_FILL`.
- `drv_en` is 0 for at least the one `S_RESULT` cycle. This lets the driver leave its done state before any new run, so a stale `drv_done` is never sampled in `S_RUN`.
- Width rules: `bcnt` is 5 bits and never wraps inside a message (capped by truncation). `m_len` is 6 bits, because 32 needs 6 bits. `drv_length[7:5]`=0.

## Timing
- Reset values (`nrst` low, asynchronous):
  - state=`S_FILL`, `bcnt`=0.
  - `drv_en`=0, `drv_length`=0.
  - `m_crc`=0, `m_len`=0, `m_trunc`=0, `m_valid`=0.
  - `s_ready` is forced 0 while `nrst` is low.
- Buffer contents are not reset.
- Reset mid-message or mid-run aborts the message with no result. The driver shares `nrst` and returns to idle.
- The last byte is accepted in cycle t; `drv_en` rises in t+1.
- With the paired driver, `drv_done` rises n+2 cycles after `drv_en` (n = byte count), and `m_valid` rises one cycle after `drv_done` is sampled.
- `s_ready` is 0 throughout `S_RUN` and `S_RESULT`. There is no buffering of the next message.
- `m_valid` holds, with `m_crc`, `m_len` and `m_trunc` stable, until the `m_ready` handshake. `m_ready` may be held high permanently.
- `drv_data` has zero-latency read. Writes and driver reads never overlap, since `S_FILL` and `S_RUN` are exclusive.

## Structure
- Package `crc_msg_pkg`:
  - state encoding `S_FILL`=0, `S_RUN`=1, `S_RESULT`=2, `S_DROP`=3
  - `WORDS`=8, `MAX_BYTES`=32
  - `LEN_W`=6
- Sub-module `crc_msg_buf`: 8 × 32 register file with byte-lane write (`we`, `widx[4:0]`, `wbyte[7:0]`) and an async read port `raddr[2:0]` → `rdata[31:0]`.
- Top level holds the FSM, `bcnt`, and the result registers.

## Test plan
- Driver stub returns `drv_crc`=16'hBEEF and asserts `drv_done` n+2 cycles after `drv_en`.
- 4 bytes 11,22,33,44 with last on 44:
  - `drv_length`=3 and `drv_data`@addr0=32'h11223344.
  - `m_crc`=16'hBEEF, `m_len`=4, `m_trunc`=0.
- 1 byte A5 with last: `drv_length`=0, word0[31:24]=A5, `m_len`=1, `m_valid` rises 4 cycles after `drv_en`.
- 35 bytes 00..22, last only on 22:
  - Cut at byte 1F: `drv_length`=31, addr7 word=32'h1C1D1E1F.
  - `m_len`=32, `m_trunc`=1.
  - Bytes 20..22 are accepted and dropped; `s_ready`=1 in `S_FILL` afterwards.
- Result backpressure: hold `m_ready`=0 for 10 cycles.
  - `m_valid` and `m_crc` stay stable; `s_ready`=0 and `drv_en`=0 throughout.
  - Release `m_ready`: next message is accepted the following cycle.
- Reset pulse of 2 cycles mid-fill (after 3 bytes) and again mid-run:
  - All outputs return to reset values immediately; no `m_valid` for the aborted message.
  - A new 2-byte message (BE, EF) completes with `m_len`=2.
